// File: rtl/pc_redirect_ctrl.sv
// Program counter owner: next-PC selection, IF/ID flush on redirects,
// syscall halt FSM and saturating statistics counters for the display.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] EXIT_CODE = 32'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             go,
  input  logic             id_valid,
  input  logic             beq,
  input  logic             bne,
  input  logic             jmp,
  input  logic             jal,
  input  logic             jr,
  input  logic             syscall,
  input  logic             rs_eq_rt,
  input  logic [31:0]      id_pc_plus4,
  input  logic [15:0]      imm16,
  input  logic [25:0]      instr_index,
  input  logic [31:0]      jr_addr,
  input  logic [31:0]      v0_val,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             flush_if,
  output logic             halted,
  output logic             display_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] uncond_cnt,
  output logic [CNT_W-1:0] cond_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             disp_q, disp_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] unc_q, unc_d;
  logic [CNT_W-1:0] cnd_q, cnd_d;

  logic        act;
  logic        sys_exit;
  logic        sys_disp;
  logic        br_taken;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] seq_pc;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Decode the ID instruction into redirect candidates and targets
  always_comb begin
    act      = id_valid & ~stall & (state_q == RUN);
    sys_exit = act & syscall & (v0_val == EXIT_CODE);
    sys_disp = act & syscall & (v0_val != EXIT_CODE);
    br_taken = (beq & rs_eq_rt) | (bne & ~rs_eq_rt);
    br_off   = {{14{imm16[15]}}, imm16, 2'b00};
    br_tgt   = id_pc_plus4 + br_off;
    j_tgt    = {id_pc_plus4[31:28], instr_index, 2'b00};
    jr_tgt   = jr_addr & 32'hFFFF_FFFC;
    seq_pc   = pc_q + 32'd4;
  end

  // Next-state, next-PC, flush and counter updates
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    disp_d   = disp_q;
    cyc_d    = cyc_q;
    unc_d    = unc_q;
    cnd_d    = cnd_q;
    flush_if = 1'b0;
    unique case (state_q)
      RUN: begin
        cyc_d  = sat_inc(cyc_q);
        disp_d = sys_disp;
        if (stall) begin
          pc_d = pc_q;
        end else if (sys_exit) begin
          pc_d     = id_pc_plus4;
          state_d  = HALT;
          flush_if = 1'b1;
        end else if (act & jr) begin
          pc_d     = jr_tgt;
          flush_if = 1'b1;
          unc_d    = sat_inc(unc_q);
        end else if (act & (jmp | jal)) begin
          pc_d     = j_tgt;
          flush_if = 1'b1;
          unc_d    = sat_inc(unc_q);
        end else if (act & br_taken) begin
          pc_d     = br_tgt;
          flush_if = 1'b1;
          cnd_d    = sat_inc(cnd_q);
        end else begin
          pc_d = seq_pc;
        end
      end
      HALT: begin
        if (go) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      disp_q  <= 1'b0;
      cyc_q   <= '0;
      unc_q   <= '0;
      cnd_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      disp_q  <= disp_d;
      cyc_q   <= cyc_d;
      unc_q   <= unc_d;
      cnd_q   <= cnd_d;
    end
  end

  assign pc         = pc_q;
  assign pc_plus4   = pc_q + 32'd4;
  assign halted     = (state_q == HALT);
  assign display_en = disp_q;
  assign cycle_cnt  = cyc_q;
  assign uncond_cnt = unc_q;
  assign cond_cnt   = cnd_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: vector table plus
// hand sequences for halt/resume and asynchronous reset.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, go, id_valid;
  logic        beq, bne, jmp, jal, jr, syscall, rs_eq_rt;
  logic [31:0] id_pc_plus4;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] jr_addr, v0_val;

  logic [31:0] pc, pc_plus4;
  logic        flush_if, halted, display_en;
  logic [31:0] cycle_cnt, uncond_cnt, cond_cnt;

  logic [31:0] s_pc, s_pc_plus4;
  logic        s_flush_if, s_halted, s_display_en;
  logic [3:0]  s_cycle_cnt, s_uncond_cnt, s_cond_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl u_dut (
    .clk(clk), .rst(rst), .stall(stall), .go(go),
    .id_valid(id_valid), .beq(beq), .bne(bne),
    .jmp(jmp), .jal(jal), .jr(jr), .syscall(syscall),
    .rs_eq_rt(rs_eq_rt), .id_pc_plus4(id_pc_plus4),
    .imm16(imm16), .instr_index(instr_index),
    .jr_addr(jr_addr), .v0_val(v0_val),
    .pc(pc), .pc_plus4(pc_plus4), .flush_if(flush_if),
    .halted(halted), .display_en(display_en),
    .cycle_cnt(cycle_cnt), .uncond_cnt(uncond_cnt),
    .cond_cnt(cond_cnt)
  );

  pc_redirect_ctrl #(.CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .stall(stall), .go(go),
    .id_valid(id_valid), .beq(beq), .bne(bne),
    .jmp(jmp), .jal(jal), .jr(jr), .syscall(syscall),
    .rs_eq_rt(rs_eq_rt), .id_pc_plus4(id_pc_plus4),
    .imm16(imm16), .instr_index(instr_index),
    .jr_addr(jr_addr), .v0_val(v0_val),
    .pc(s_pc), .pc_plus4(s_pc_plus4),
    .flush_if(s_flush_if), .halted(s_halted),
    .display_en(s_display_en), .cycle_cnt(s_cycle_cnt),
    .uncond_cnt(s_uncond_cnt), .cond_cnt(s_cond_cnt)
  );

  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] p4;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jra;
    logic [31:0] v0;
    logic        xf;
    logic [31:0] xpc;
    logic [31:0] xcyc;
    logic [31:0] xcnd;
    logic [31:0] xunc;
    logic        xdsp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ctl bits: {stall,id_valid,beq,bne,jmp,jal,jr,syscall,rs_eq_rt}
  task automatic drive(input logic [8:0] c, input logic [31:0] p4,
                       input logic [15:0] im, input logic [25:0] ix,
                       input logic [31:0] ja, input logic [31:0] v0);
    {stall, id_valid, beq, bne, jmp, jal, jr, syscall, rs_eq_rt} = c;
    id_pc_plus4 = p4;
    imm16       = im;
    instr_index = ix;
    jr_addr     = ja;
    v0_val      = v0;
  endtask

  task automatic add(input logic [8:0] c, input logic [31:0] p4,
                     input logic [15:0] im, input logic [25:0] ix,
                     input logic [31:0] ja, input logic [31:0] v0,
                     input logic xf, input logic [31:0] xpc,
                     input int xcyc, input int xcnd, input int xunc,
                     input logic xdsp);
    vec_t v;
    v.ctl = c;  v.p4 = p4; v.imm = im; v.idx = ix;
    v.jra = ja; v.v0 = v0; v.xf = xf;  v.xpc = xpc;
    v.xcyc = 32'(xcyc); v.xcnd = 32'(xcnd);
    v.xunc = 32'(xunc); v.xdsp = xdsp;
    tbl.push_back(v);
  endtask

  localparam logic [8:0] BUB  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] BEQT = 9'b0_1_1_0_0_0_0_0_1;
  localparam logic [8:0] BEQN = 9'b0_1_1_0_0_0_0_0_0;
  localparam logic [8:0] BEQS = 9'b1_1_1_0_0_0_0_0_1;
  localparam logic [8:0] JRV  = 9'b0_1_0_0_0_0_1_0_0;
  localparam logic [8:0] JALV = 9'b0_1_0_0_0_1_0_0_0;
  localparam logic [8:0] JMPV = 9'b0_1_0_0_1_0_0_0_0;
  localparam logic [8:0] JMPB = 9'b0_0_0_0_1_0_0_0_0;
  localparam logic [8:0] BNET = 9'b0_1_0_1_0_0_0_0_0;
  localparam logic [8:0] BNEN = 9'b0_1_0_1_0_0_0_0_1;
  localparam logic [8:0] SYSV = 9'b0_1_0_0_0_0_0_1_0;
  localparam logic [8:0] JRBQ = 9'b0_1_1_0_0_0_1_0_1;

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    drive(BUB, 0, 0, 0, 0, 0);

    // ctl, p4, imm, idx, jra, v0 | flush, pc, cyc, cnd, unc, disp
    add(BUB,  0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0, 0);
    add(BUB,  0, 0, 0, 0, 0, 0, 32'h8, 2, 0, 0, 0);
    add(BUB,  0, 0, 0, 0, 0, 0, 32'hC, 3, 0, 0, 0);
    add(BUB,  0, 0, 0, 0, 0, 0, 32'h10, 4, 0, 0, 0);
    add(BEQT, 32'h40, 16'hFFFE, 0, 0, 0,
        1, 32'h38, 5, 1, 0, 0);
    add(BEQN, 32'h40, 16'hFFFE, 0, 0, 0,
        0, 32'h3C, 6, 1, 0, 0);
    add(BEQS, 32'h40, 16'hFFFE, 0, 0, 0,
        0, 32'h3C, 7, 1, 0, 0);
    add(BEQS, 32'h40, 16'hFFFE, 0, 0, 0,
        0, 32'h3C, 8, 1, 0, 0);
    add(BEQS, 32'h40, 16'hFFFE, 0, 0, 0,
        0, 32'h3C, 9, 1, 0, 0);
    add(BEQT, 32'h40, 16'hFFFE, 0, 0, 0,
        1, 32'h38, 10, 2, 0, 0);
    add(JRV, 0, 0, 0, 32'h1003, 0,
        1, 32'h1000, 11, 2, 1, 0);
    add(JALV, 32'hA000_0010, 0, 26'h100, 0, 0,
        1, 32'hA000_0400, 12, 2, 2, 0);
    add(BNET, 32'h100, 16'h0004, 0, 0, 0,
        1, 32'h110, 13, 3, 2, 0);
    add(BNEN, 32'h100, 16'h0004, 0, 0, 0,
        0, 32'h114, 14, 3, 2, 0);
    add(JMPB, 32'h100, 0, 26'h55, 0, 0,
        0, 32'h118, 15, 3, 2, 0);
    add(SYSV, 0, 0, 0, 0, 32'd34,
        0, 32'h11C, 16, 3, 2, 1);
    add(BUB,  0, 0, 0, 0, 0, 0, 32'h120, 17, 3, 2, 0);
    add(JMPV, 32'h1000_0004, 0, 26'h3FF_FFFF, 0, 0,
        1, 32'h1FFF_FFFC, 18, 3, 3, 0);
    add(BUB,  0, 0, 0, 0, 0, 0, 32'h2000_0000, 19, 3, 3, 0);
    add(BEQT, 32'hFFFF_FFF0, 16'h0008, 0, 0, 0,
        1, 32'h10, 20, 4, 3, 0);
    add(JRBQ, 32'h40, 16'hFFFE, 0, 32'h200, 0,
        1, 32'h200, 21, 4, 4, 0);
    add(JRV, 0, 0, 0, 32'hFFFF_FFFF, 0,
        1, 32'hFFFF_FFFC, 22, 4, 5, 0);
    add(BUB,  0, 0, 0, 0, 0, 0, 32'h0, 23, 4, 5, 0);

    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_disp", 32'(display_en), 32'h0);
    chk("rst_cyc", cycle_cnt, 32'h0);
    chk("rst_cnd", cond_cnt, 32'h0);
    chk("rst_unc", uncond_cnt, 32'h0);
    chk("rst_flush", 32'(flush_if), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].ctl, tbl[i].p4, tbl[i].imm, tbl[i].idx,
            tbl[i].jra, tbl[i].v0);
      #1;
      chk($sformatf("v%0d_flush", i), 32'(flush_if),
          32'(tbl[i].xf));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i), pc, tbl[i].xpc);
      chk($sformatf("v%0d_pc4", i), pc_plus4,
          tbl[i].xpc + 32'd4);
      chk($sformatf("v%0d_cyc", i), cycle_cnt, tbl[i].xcyc);
      chk($sformatf("v%0d_cnd", i), cond_cnt, tbl[i].xcnd);
      chk($sformatf("v%0d_unc", i), uncond_cnt, tbl[i].xunc);
      chk($sformatf("v%0d_disp", i), 32'(display_en),
          32'(tbl[i].xdsp));
      @(negedge clk);
    end

    chk("small_cyc_sat", 32'(s_cycle_cnt), 32'hF);

    // syscall exit into HALT
    drive(SYSV, 32'h80, 0, 0, 0, 32'd10);
    #1;
    chk("exit_flush", 32'(flush_if), 32'h1);
    @(posedge clk);
    #1;
    chk("exit_halted", 32'(halted), 32'h1);
    chk("exit_pc", pc, 32'h80);
    chk("exit_cyc", cycle_cnt, 32'd24);
    chk("exit_unc", uncond_cnt, 32'd5);
    chk("exit_cnd", cond_cnt, 32'd4);

    // HALT freezes everything even with live ID controls
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(JMPV, 32'h1000_0000, 0, 26'h10, 0, 0);
      #1;
      chk("halt_flush", 32'(flush_if), 32'h0);
      @(posedge clk);
      #1;
      chk("halt_pc", pc, 32'h80);
      chk("halt_cyc", cycle_cnt, 32'd24);
      chk("halt_unc", uncond_cnt, 32'd5);
      chk("halt_state", 32'(halted), 32'h1);
    end

    // go resumes at the held pc
    @(negedge clk);
    drive(BUB, 0, 0, 0, 0, 0);
    go = 1'b1;
    @(posedge clk);
    #1;
    chk("go_halted", 32'(halted), 32'h0);
    chk("go_pc", pc, 32'h80);
    chk("go_cyc", cycle_cnt, 32'd24);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    chk("resume_pc", pc, 32'h84);
    chk("resume_cyc", cycle_cnt, 32'd25);

    // go in RUN is ignored
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1;
    chk("go_run_pc", pc, 32'h88);
    chk("go_run_halted", 32'(halted), 32'h0);

    // halt again, then asynchronous reset with no clock edge
    @(negedge clk);
    go = 1'b0;
    drive(SYSV, 32'h300, 0, 0, 0, 32'd10);
    @(posedge clk);
    #1;
    chk("exit2_halted", 32'(halted), 32'h1);
    chk("exit2_pc", pc, 32'h300);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_halted", 32'(halted), 32'h0);
    chk("arst_cyc", cycle_cnt, 32'h0);
    chk("arst_unc", uncond_cnt, 32'h0);
    chk("arst_cnd", cond_cnt, 32'h0);
    chk("arst_small_cyc", 32'(s_cycle_cnt), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    drive(BUB, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("post_rst_pc", pc, 32'h4);
    chk("post_rst_cyc", cycle_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Consumes the ID-stage decoded control signals (Beq, Bne, Jmp, Jal, Jr, Syscall) from the instruction decoder.
- Owns the program counter: computes the next PC, issues the IF/ID flush on redirects, and runs the halt state machine for syscall exit.
- Keeps saturating cycle and taken-control-transfer counters for the board display.
- Sits between the hazard unit (stall), the ID stage (decoded controls, operands) and the instruction memory address port.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of each statistics counter
EXIT_CODE, 32'd10, $v0 value that makes a syscall halt the core

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hazard-unit stall; holds PC and suppresses ID actions
go  input  1  resume request, honoured only in HALT
id_valid  input  1  ID holds a real instruction (0 = bubble; all ID controls ignored)
beq  input  1  decoded Beq
bne  input  1  decoded Bne
jmp  input  1  decoded Jmp
jal  input  1  decoded Jal
jr  input  1  decoded Jr
syscall  input  1  decoded Syscall
rs_eq_rt  input  1  forwarded register compare result
id_pc_plus4  input  32  PC+4 of the ID instruction
imm16  input  16  branch offset field
instr_index  input  26  jump target field
jr_addr  input  32  forwarded rs value for jr
v0_val  input  32  forwarded $v0 value for syscall
pc  output  32  fetch address (registered)
pc_plus4  output  32  pc+4, combinational
flush_if  output  1  load bubble into IF/ID this cycle, combinational
halted  output  1  1 in HALT state
display_en  output  1  one-cycle pulse for a non-exit syscall, registered
cycle_cnt  output  CNT_W  RUN cycles, saturating
uncond_cnt  output  CNT_W  taken jmp/jal/jr, saturating
cond_cnt  output  CNT_W  taken beq/bne, saturating

Behaviour:
- States: RUN, HALT. Reset state is RUN.
- Reset values: pc=RESET_PC, halted=0, display_en=0, all counters 0.
- act = id_valid & ~stall & (state==RUN).
- Control events are evaluated only when act is 1.
- Next-PC priority, highest first:
  - stall or HALT: hold PC.
  - act & syscall & v0_val==EXIT_CODE: pc<=id_pc_plus4, go to HALT, flush_if=1.
  - act & jr: pc<={jr_addr[31:2],2'b00}, flush_if=1.
  - act & (jmp|jal): pc<={id_pc_plus4[31:28],instr_index,2'b00}, flush_if=1.
  - act & ((beq&rs_eq_rt)|(bne&~rs_eq_rt)): pc<=id_pc_plus4+({{14{imm16[15]}},imm16,2'b00}), modulo 2^32 with wrap, flush_if=1.
  - otherwise: pc<=pc+4, wraps 32'hFFFF_FFFC to 0.
- Redirect latency: the target appears on pc one cycle after the ID cycle. There is exactly one flushed fetch; there is no delay slot.
- flush_if=0 whenever stall=1. Stall during a pending branch delays resolution to the first non-stalled cycle.
- display_en=1 in the cycle after act & syscall & v0_val!=EXIT_CODE. The PC then continues sequentially with no flush.
- HALT:
  - pc, counters and display_en are frozen; flush_if=0.
  - go=1 returns to RUN next cycle, and fetch resumes at the held pc.
  - go in RUN is ignored.
- cycle_cnt increments on every RUN cycle, stalled cycles included.
- uncond_cnt increments on a taken jr/jmp/jal; cond_cnt increments on a taken branch. A syscall-exit counts in neither.
- All counters saturate at all-ones.
- rst asserted at any point, including in HALT or mid-redirect, returns all state to reset values immediately.

Test Plan:
- Reset, then 4 bubble cycles -> pc sequence 0,4,8,12,16; cycle_cnt=4; flush_if=0 throughout.
- beq, rs_eq_rt=1, id_pc_plus4=0x40, imm16=0xFFFE, act -> flush_if=1 that cycle; pc=0x38 next; cond_cnt=1. Same with rs_eq_rt=0 -> pc+4, no flush.
- Same beq held with stall=1 for 3 cycles -> pc constant, flush_if=0, cycle_cnt +3; first unstalled cycle redirects to 0x38.
- jr jr_addr=0x1003 -> pc=0x1000. jal id_pc_plus4=0xA000_0010, instr_index=0x0000100 -> pc=0xA000_0400; uncond_cnt=2.
- syscall v0=34 -> display_en pulse, no flush. syscall v0=10, id_pc_plus4=0x80 -> halted=1, pc=0x80 frozen, counters frozen; go -> RUN, pc 0x84 next.
- CNT_W=4, 20 RUN cycles -> cycle_cnt stays 4'hF. rst asserted in HALT -> pc=RESET_PC, halted=0 with no clock edge.
